// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
//   Command front end between the UART receiver and the stopwatch/watch core.
//   Received ASCII bytes become button pulses, a mode toggle, a soft clear and
//   a framed multi-digit time-set command ('T' + SET_DIGITS digits + CR).
//   Malformed input and set-command timeouts raise a one-cycle err strobe.
//
//   Optional feature macro: UART_CMD_ECHO_EN
//     defined   : received bytes are echoed through a one-entry buffer
//     undefined : tx_data/tx_start tied to zero, tx_busy ignored
//
// Ports
//   clk          system clock
//   rst          asynchronous reset, active-low
//   rx_data      received byte, valid when rx_done=1
//   rx_done      one-cycle strobe, byte available
//   btn_pulse    one-hot button pulse, PULSE_CYC cycles long
//   mode         level, toggled by 'M'/'m'
//   clear_pulse  one-cycle soft-clear strobe
//   set_value    committed BCD digits, first received digit in the top nibble
//   set_valid    one-cycle strobe, set_value updated
//   err          one-cycle error strobe
//   busy         high while a set command is in progress
//   tx_data      echo byte
//   tx_start     echo start strobe
//   tx_busy      UART transmitter busy
module uart_cmd_parser #(
    parameter int unsigned N_BTN       = 4,
    parameter int unsigned PULSE_CYC   = 1,
    parameter int unsigned SET_DIGITS  = 6,
    parameter int unsigned TIMEOUT_CYC = 100_000_000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              rx_data,
    input  logic                    rx_done,
    output logic [N_BTN-1:0]        btn_pulse,
    output logic                    mode,
    output logic                    clear_pulse,
    output logic [4*SET_DIGITS-1:0] set_value,
    output logic                    set_valid,
    output logic                    err,
    output logic                    busy,
    output logic [7:0]              tx_data,
    output logic                    tx_start,
    input  logic                    tx_busy
);

    localparam int unsigned PW = $clog2(PULSE_CYC + 1);
    localparam int unsigned TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int unsigned IW = (SET_DIGITS > 1) ? $clog2(SET_DIGITS) : 1;
    localparam int unsigned VW = 4 * SET_DIGITS;

    typedef enum logic [1:0] {IDLE, SET_DIG, SET_END} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [VW-1:0]   shadow_q, shadow_d;
    logic [TW-1:0]   to_q, to_d;
    logic [PW-1:0]   cnt_q, cnt_d;
    logic [N_BTN-1:0] btn_q, btn_d;
    logic            mode_q, mode_d;
    logic            clr_q, clr_d;
    logic [VW-1:0]   setv_q, setv_d;
    logic            sv_q, sv_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;

    logic [7:0]      btn_off;
    logic            is_digit;

    assign btn_off  = rx_data - 8'h31;
    assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        to_d     = to_q;
        cnt_d    = cnt_q;
        btn_d    = btn_q;
        mode_d   = mode_q;
        clr_d    = 1'b0;
        setv_d   = setv_q;
        sv_d     = 1'b0;
        err_d    = 1'b0;

        if (cnt_q != '0) begin
            if (cnt_q == PW'(1)) begin
                btn_d = '0;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q - PW'(1);
            end
        end

        case (state_q)
            IDLE: begin
                to_d = '0;
                if (rx_done) begin
                    if (rx_data >= 8'h31 && 32'(btn_off) < N_BTN) begin
                        // new command replaces any active pulse
                        btn_d = N_BTN'(1) << btn_off;
                        cnt_d = PW'(PULSE_CYC);
                    end else if (rx_data == 8'h4D || rx_data == 8'h6D) begin
                        mode_d = ~mode_q;
                    end else if (rx_data == 8'h43 || rx_data == 8'h63) begin
                        clr_d = 1'b1;
                    end else if (rx_data == 8'h54 || rx_data == 8'h74) begin
                        idx_d    = '0;
                        shadow_d = '0;
                        state_d  = SET_DIG;
                    end else if (rx_data == 8'h0D || rx_data == 8'h0A) begin
                        err_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SET_DIG: begin
                if (rx_done) begin
                    // a byte always beats a timeout firing in the same cycle
                    to_d = '0;
                    if (is_digit) begin
                        shadow_d[4*(SET_DIGITS-1-32'(idx_q)) +: 4] = rx_data[3:0];
                        idx_d = idx_q + IW'(1);
                        if (idx_q == IW'(SET_DIGITS - 1)) begin
                            state_d = SET_END;
                        end
                    end else begin
                        err_d    = 1'b1;
                        shadow_d = '0;
                        state_d  = IDLE;
                    end
                end else if (to_q == TW'(TIMEOUT_CYC - 1)) begin
                    err_d    = 1'b1;
                    shadow_d = '0;
                    state_d  = IDLE;
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            SET_END: begin
                if (rx_done) begin
                    to_d = '0;
                    if (rx_data == 8'h0D) begin
                        setv_d = shadow_q;
                        sv_d   = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    shadow_d = '0;
                    state_d  = IDLE;
                end else if (to_q == TW'(TIMEOUT_CYC - 1)) begin
                    err_d    = 1'b1;
                    shadow_d = '0;
                    state_d  = IDLE;
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            shadow_q <= '0;
            to_q     <= '0;
            cnt_q    <= '0;
            btn_q    <= '0;
            mode_q   <= 1'b0;
            clr_q    <= 1'b0;
            setv_q   <= '0;
            sv_q     <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            to_q     <= to_d;
            cnt_q    <= cnt_d;
            btn_q    <= btn_d;
            mode_q   <= mode_d;
            clr_q    <= clr_d;
            setv_q   <= setv_d;
            sv_q     <= sv_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    assign btn_pulse   = btn_q;
    assign mode        = mode_q;
    assign clear_pulse = clr_q;
    assign set_value   = setv_q;
    assign set_valid   = sv_q;
    assign err         = err_q;
    assign busy        = busy_q;

`ifdef UART_CMD_ECHO_EN
    logic       echo_full_q, echo_full_d;
    logic [7:0] echo_byte_q, echo_byte_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_start_q, tx_start_d;

    always_comb begin
        echo_full_d = echo_full_q;
        echo_byte_d = echo_byte_q;
        tx_data_d   = tx_data_q;
        tx_start_d  = 1'b0;
        if (echo_full_q && !tx_busy) begin
            tx_data_d   = echo_byte_q;
            tx_start_d  = 1'b1;
            echo_full_d = 1'b0;
        end
        // a byte landing while the buffer is still full is dropped, even if
        // the buffer drains in this same cycle
        if (rx_done && !echo_full_q) begin
            echo_byte_d = rx_data;
            echo_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            echo_full_q <= 1'b0;
            echo_byte_q <= '0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
        end else begin
            echo_full_q <= echo_full_d;
            echo_byte_q <= echo_byte_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;
`else
    logic unused_tx_busy;
    assign unused_tx_busy = tx_busy;
    assign tx_data        = '0;
    assign tx_start       = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Testbench for uart_cmd_parser (N_BTN=4, PULSE_CYC=3, SET_DIGITS=6,
// TIMEOUT_CYC=50). Inputs change on the falling edge; outputs are sampled
// 1 time unit after the rising edge that follows.
module tb_uart_cmd_parser;

    localparam logic [23:0] S0 = 24'h000000;
    localparam logic [23:0] S1 = 24'h123456;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic [3:0]  btn_pulse;
    logic        mode, clear_pulse, set_valid, err, busy;
    logic [23:0] set_value;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;

    int n_vec = 0;
    int n_bad = 0;

    uart_cmd_parser #(
        .N_BTN(4),
        .PULSE_CYC(3),
        .SET_DIGITS(6),
        .TIMEOUT_CYC(50)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_data(rx_data),
        .rx_done(rx_done),
        .btn_pulse(btn_pulse),
        .mode(mode),
        .clear_pulse(clear_pulse),
        .set_value(set_value),
        .set_valid(set_valid),
        .err(err),
        .busy(busy),
        .tx_data(tx_data),
        .tx_start(tx_start),
        .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  d;
        logic        v;
        logic [3:0]  btn;
        logic        mode;
        logic        clr;
        logic        sv;
        logic        err;
        logic        busy;
        logic [23:0] set;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [7:0] d, input logic v,
                                input logic [3:0] b, input logic m,
                                input logic c, input logic s,
                                input logic e, input logic y,
                                input logic [23:0] st);
        vec_t r;
        r.d = d; r.v = v; r.btn = b; r.mode = m; r.clr = c;
        r.sv = s; r.err = e; r.busy = y; r.set = st;
        return r;
    endfunction

    task automatic drive(input logic [7:0] d, input logic v);
        @(negedge clk);
        rx_data = d;
        rx_done = v;
        @(posedge clk);
        #1;
        rx_done = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [3:0] b, input logic m,
                       input logic c, input logic s, input logic e,
                       input logic y, input logic [23:0] st);
        logic [32:0] act, exp;
        act = {btn_pulse, mode, clear_pulse, set_valid, err, busy, set_value};
        exp = {b, m, c, s, e, y, st};
`ifndef UART_CMD_ECHO_EN
        act = act | 33'({tx_start, tx_data} != 9'h0);
`endif
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: btn/mode/clr/sv/err/busy/set got %b %b %b %b %b %b %h tx %b %h, want %b %b %b %b %b %b %h",
                     nm, btn_pulse, mode, clear_pulse, set_valid, err, busy,
                     set_value, tx_start, tx_data, b, m, c, s, e, y, st);
        end
    endtask

    task automatic chk_val(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    initial begin
        int hit;
        logic busy_at_hit;

        rst = 1'b0; rx_data = 8'h00; rx_done = 1'b0; tx_busy = 1'b0;

        // hand-computed single-byte-per-cycle stream
        tbl.push_back(mk(8'h32,1,4'b0010,0,0,0,0,0,S0)); // '2'
        tbl.push_back(mk(8'h00,0,4'b0010,0,0,0,0,0,S0));
        tbl.push_back(mk(8'h00,0,4'b0010,0,0,0,0,0,S0));
        tbl.push_back(mk(8'h00,0,4'b0000,0,0,0,0,0,S0));
        tbl.push_back(mk(8'h31,1,4'b0001,0,0,0,0,0,S0)); // '1'
        tbl.push_back(mk(8'h00,0,4'b0001,0,0,0,0,0,S0));
        tbl.push_back(mk(8'h33,1,4'b0100,0,0,0,0,0,S0)); // '3' replaces
        tbl.push_back(mk(8'h00,0,4'b0100,0,0,0,0,0,S0));
        tbl.push_back(mk(8'h00,0,4'b0100,0,0,0,0,0,S0));
        tbl.push_back(mk(8'h00,0,4'b0000,0,0,0,0,0,S0));
        tbl.push_back(mk(8'h54,1,4'b0000,0,0,0,0,1,S0)); // 'T'
        tbl.push_back(mk(8'h31,1,4'b0000,0,0,0,0,1,S0)); // digits are not buttons here
        tbl.push_back(mk(8'h32,1,4'b0000,0,0,0,0,1,S0));
        tbl.push_back(mk(8'h33,1,4'b0000,0,0,0,0,1,S0));
        tbl.push_back(mk(8'h34,1,4'b0000,0,0,0,0,1,S0));
        tbl.push_back(mk(8'h35,1,4'b0000,0,0,0,0,1,S0));
        tbl.push_back(mk(8'h36,1,4'b0000,0,0,0,0,1,S0));
        tbl.push_back(mk(8'h0D,1,4'b0000,0,0,1,0,0,S1)); // CR commits
        tbl.push_back(mk(8'h00,0,4'b0000,0,0,0,0,0,S1));
        tbl.push_back(mk(8'h74,1,4'b0000,0,0,0,0,1,S1)); // 't'
        tbl.push_back(mk(8'h31,1,4'b0000,0,0,0,0,1,S1));
        tbl.push_back(mk(8'h32,1,4'b0000,0,0,0,0,1,S1));
        tbl.push_back(mk(8'h58,1,4'b0000,0,0,0,1,0,S1)); // 'X' aborts
        tbl.push_back(mk(8'h00,0,4'b0000,0,0,0,0,0,S1));
        tbl.push_back(mk(8'h4D,1,4'b0000,1,0,0,0,0,S1)); // 'M'
        tbl.push_back(mk(8'h6D,1,4'b0000,0,0,0,0,0,S1)); // 'm'
        tbl.push_back(mk(8'h63,1,4'b0000,0,1,0,0,0,S1)); // 'c'
        tbl.push_back(mk(8'h00,0,4'b0000,0,0,0,0,0,S1));
        tbl.push_back(mk(8'h3F,1,4'b0000,0,0,0,1,0,S1)); // '?'
        tbl.push_back(mk(8'h0A,1,4'b0000,0,0,0,0,0,S1)); // LF ignored
        tbl.push_back(mk(8'h0D,1,4'b0000,0,0,0,0,0,S1)); // CR ignored
        tbl.push_back(mk(8'h35,1,4'b0000,0,0,0,1,0,S1)); // '5' beyond N_BTN
        tbl.push_back(mk(8'h30,1,4'b0000,0,0,0,1,0,S1)); // '0' below '1'
        tbl.push_back(mk(8'h54,1,4'b0000,0,0,0,0,1,S1));
        tbl.push_back(mk(8'h54,1,4'b0000,0,0,0,1,0,S1)); // 'T' inside SET_DIG
        tbl.push_back(mk(8'h74,1,4'b0000,0,0,0,0,1,S1));
        tbl.push_back(mk(8'h0D,1,4'b0000,0,0,0,1,0,S1)); // early CR
        tbl.push_back(mk(8'h54,1,4'b0000,0,0,0,0,1,S1));
        tbl.push_back(mk(8'h39,1,4'b0000,0,0,0,0,1,S1));
        tbl.push_back(mk(8'h38,1,4'b0000,0,0,0,0,1,S1));
        tbl.push_back(mk(8'h37,1,4'b0000,0,0,0,0,1,S1));
        tbl.push_back(mk(8'h36,1,4'b0000,0,0,0,0,1,S1));
        tbl.push_back(mk(8'h35,1,4'b0000,0,0,0,0,1,S1));
        tbl.push_back(mk(8'h34,1,4'b0000,0,0,0,0,1,S1)); // now SET_END
        tbl.push_back(mk(8'h4D,1,4'b0000,0,0,0,1,0,S1)); // 'M' in SET_END
        tbl.push_back(mk(8'h34,1,4'b1000,0,0,0,0,0,S1)); // '4' top channel
        tbl.push_back(mk(8'h00,0,4'b1000,0,0,0,0,0,S1));
        tbl.push_back(mk(8'h00,0,4'b1000,0,0,0,0,0,S1));
        tbl.push_back(mk(8'h00,0,4'b0000,0,0,0,0,0,S1));

        repeat (3) @(posedge clk);
        #1;
        chk("reset", 4'b0000, 0, 0, 0, 0, 0, S0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].d, tbl[i].v);
            chk($sformatf("vec%0d", i), tbl[i].btn, tbl[i].mode, tbl[i].clr,
                tbl[i].sv, tbl[i].err, tbl[i].busy, tbl[i].set);
        end

        // timeout: err exactly 50 cycles after the last digit
        drive(8'h54, 1'b1);
        drive(8'h39, 1'b1);
        chk("to_start", 4'b0000, 0, 0, 0, 0, 1, S1);
        hit = 0;
        busy_at_hit = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            drive(8'h00, 1'b0);
            if (err === 1'b1) begin
                hit = k;
                busy_at_hit = busy;
                break;
            end
        end
        chk_val("timeout_cycles", hit, 50);
        chk_val("timeout_busy", int'(busy_at_hit), 0);
        drive(8'h00, 1'b0);
        chk("after_timeout", 4'b0000, 0, 0, 0, 0, 0, S1);

        // byte arriving in the timeout cycle wins
        drive(8'h54, 1'b1);
        for (int k = 1; k <= 49; k++) drive(8'h00, 1'b0);
        drive(8'h35, 1'b1);
        chk("byte_beats_timeout", 4'b0000, 0, 0, 0, 0, 1, S1);
        drive(8'h0D, 1'b1);
        chk("early_cr_err", 4'b0000, 0, 0, 0, 1, 0, S1);

`ifdef UART_CMD_ECHO_EN
        drive(8'h00, 1'b0);
        drive(8'h00, 1'b0);
        @(negedge clk);
        tx_busy = 1'b1;
        drive(8'h41, 1'b1);
        chk("echo_A_err", 4'b0000, 0, 0, 0, 1, 0, S1);
        chk_val("echo_A_nostart", int'(tx_start), 0);
        drive(8'h42, 1'b1);
        chk("echo_B_err", 4'b0000, 0, 0, 0, 1, 0, S1);
        drive(8'h00, 1'b0);
        chk_val("echo_held", int'(tx_start), 0);
        @(negedge clk);
        tx_busy = 1'b0;
        @(posedge clk);
        #1;
        chk_val("echo_start", int'(tx_start), 1);
        chk_val("echo_data", int'(tx_data), 8'h41);
        drive(8'h00, 1'b0);
        chk_val("echo_once", int'(tx_start), 0);
`endif

        // asynchronous reset in the middle of a set command
        drive(8'h54, 1'b1);
        drive(8'h31, 1'b1);
        chk("mid_busy", 4'b0000, 0, 0, 0, 0, 1, S1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_reset", 4'b0000, 0, 0, 0, 0, 0, S0);
        @(negedge clk);
        rst = 1'b1;
        drive(8'h00, 1'b0);
        chk("post_reset", 4'b0000, 0, 0, 0, 0, 0, S0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Parametrised command front end between the UART receiver and the stopwatch/watch core.
- Turns received ASCII bytes into button pulses (N_BTN channels), a mode toggle, a soft clear, and a framed multi-digit time-set command.
- Reports bad input with an error strobe.
- Replaces the fixed single-byte button mapping with configurable channel count, pulse width and set-command length.

Parameters:
- N_BTN, 4, number of button channels (1..9); channel i is triggered by ASCII '1'+i.
- PULSE_CYC, 1, length of each button pulse in clk cycles (>=1).
- SET_DIGITS, 6, number of BCD digits in the set command (1..8).
- TIMEOUT_CYC, 100_000_000, idle cycles allowed between bytes of a set command before it is aborted.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-low
- rx_data  input  8  received byte, valid when rx_done=1
- rx_done  input  1  one-cycle strobe, byte available
- btn_pulse  output  N_BTN  one-hot button pulse, PULSE_CYC cycles long
- mode  output  1  level, toggled by 'M'/'m'
- clear_pulse  output  1  one-cycle soft-clear strobe
- set_value  output  4*SET_DIGITS  BCD digits; first received digit is in the most-significant nibble
- set_valid  output  1  one-cycle strobe, set_value updated
- err  output  1  one-cycle error strobe
- busy  output  1  high while a set command is in progress
- tx_data  output  8  echo byte (see Optional Feature)
- tx_start  output  1  echo start strobe
- tx_busy  input  1  UART transmitter busy

Behaviour:
- Reset (rst=0, async): state=IDLE.
  - btn_pulse, mode, clear_pulse, set_valid, err, busy, tx_start = 0.
  - set_value = 0, tx_data = 0.
  - Pulse and timeout counters = 0.
- All outputs are registered. Responses appear on the clk edge after the cycle in which rx_done=1 (latency 1).
- FSM states: IDLE, SET_DIG, SET_END.
- IDLE command decode:
  - '1'+i with i<N_BTN: btn_pulse = one-hot(i), pulse counter loaded with PULSE_CYC.
  - 'M'/'m': mode toggles.
  - 'C'/'c': clear_pulse = 1 for one cycle.
  - 'T'/'t': clear the digit index, clear the timeout counter, go to SET_DIG, busy=1.
  - CR (0x0D) or LF (0x0A): silently ignored.
  - Any other byte: err = 1 for one cycle.
- Button pulse timing:
  - btn_pulse holds for exactly PULSE_CYC cycles, then returns to 0.
  - A new button command while a pulse is active replaces the previous channel and reloads the counter. Bits are never ORed.
- SET_DIG:
  - '0'..'9': nibble stored in a shadow register at the digit index, index increments.
  - When index reaches SET_DIGITS, go to SET_END.
  - Non-digit (including an early CR): err=1, discard shadow, go to IDLE.
- SET_END:
  - CR: set_value <= shadow, set_valid=1 for one cycle, go to IDLE.
  - Any other byte: err=1, go to IDLE; set_value unchanged.
- Timeout:
  - In SET_DIG/SET_END the counter increments each cycle and clears on every rx_done.
  - When it reaches TIMEOUT_CYC-1 with no byte: err=1, go to IDLE.
- Button, 'M' and 'C' commands are not recognised in the SET states; those bytes follow the SET_DIG/SET_END rules.
- Simultaneous events: rx_done in the same cycle the timeout fires → the byte wins and the timeout is discarded.
- busy = (state != IDLE), registered.
- set_value keeps its last committed value indefinitely. A failed set never modifies it.

Optional Feature:
- Macro: UART_CMD_ECHO_EN.
- Defined:
  - Every byte accepted with rx_done is loaded into a one-entry echo register.
  - When the register is full and tx_busy=0: tx_data = the byte, tx_start=1 for one cycle, register empties.
  - A byte arriving while the register is full is not echoed; it is still parsed.
- Not defined: tx_start=0 and tx_data=0 permanently, tx_busy is ignored, no echo logic is synthesised.

Test Plan:
- Reset → all outputs 0; release rst, send '2' (0x32), N_BTN=4, PULSE_CYC=3 → btn_pulse=4'b0010 for exactly 3 cycles, starting 1 cycle after rx_done.
- Send '1', then '3' two cycles later (PULSE_CYC=3) → btn_pulse=0001 for 2 cycles, then 0100 for 3 cycles; no overlap.
- Send 'T','1','2','3','4','5','6',CR (SET_DIGITS=6) → busy high from after 'T' until after CR; set_value=24'h123456; set_valid pulses once.
- Send 'T','1','2','X' → err pulse after 'X'; state IDLE; set_value unchanged (still 24'h123456).
- Send 'T','9' then idle TIMEOUT_CYC cycles (TIMEOUT_CYC=50 in bench) → err after 50 cycles, busy=0. Then 'M','m' → mode toggles 0→1→0. Then 'C' → one clear_pulse. Then '?' → err.
- With UART_CMD_ECHO_EN and tx_busy=1: send 'A','B' → no tx_start; drop tx_busy → tx_start once with tx_data=0x41 ('B' dropped; err pulses for both bytes).
- Mid-command reset: assert rst after 'T','1' → state IDLE, busy=0, set_value=0.
